// File: rtl/skid_fifo.sv
// skid_fifo: synchronous FIFO whose head entry lives in a dedicated output
// register, so rdata is always driven straight from a flop. The remaining
// DEPTH-1 entries sit in a circular buffer behind it. Occupancy, full,
// empty and a programmable almost-full flag are all registered.
module skid_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int W_LEVEL      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               wen,
  output logic [WIDTH-1:0]   rdata,
  input  logic               ren,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic [W_LEVEL-1:0] level
);

  // The circular buffer holds everything except the head entry.
  localparam int BUF_DEPTH = DEPTH - 1;
  // With a single buffer entry the pointers are constant 0 but keep one bit.
  localparam int W_PTR = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [W_PTR-1:0]   PTR_LAST  = W_PTR'(BUF_DEPTH - 1);
  localparam logic [W_LEVEL-1:0] LEVEL_MAX = W_LEVEL'(DEPTH);
  localparam logic [W_LEVEL-1:0] LEVEL_AF  = W_LEVEL'(AFULL_THRESH);
  localparam logic [W_LEVEL-1:0] LEVEL_ONE = W_LEVEL'(1);
  localparam logic [W_LEVEL-1:0] LEVEL_TWO = W_LEVEL'(2);

  // Advance a buffer pointer, wrapping explicitly because BUF_DEPTH need
  // not be a power of two.
  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + W_PTR'(1);
  endfunction

  logic [WIDTH-1:0]   mem [BUF_DEPTH];
  logic [W_PTR-1:0]   rptr;
  logic [W_PTR-1:0]   wptr;

  logic               push;
  logic               pop;
  logic               head_from_wdata;
  logic               head_from_buf;
  logic               buf_write;
  logic [W_LEVEL-1:0] level_next;

  // Decide what moves this cycle. Illegal requests (push when full, pop when
  // empty) are masked so they cannot disturb state. The head takes wdata
  // directly when the FIFO is empty or when the only resident entry is
  // being popped; otherwise the head refills from the buffer on a pop and
  // new data lands in the buffer.
  always_comb begin
    push            = wen && !full;
    pop             = ren && !empty;
    head_from_wdata = 1'b0;
    head_from_buf   = 1'b0;
    buf_write       = 1'b0;
    level_next      = level;

    if (flush) begin
      level_next = '0;
    end else begin
      head_from_wdata = push && ((level == '0) || (pop && (level == LEVEL_ONE)));
      head_from_buf   = pop && (level >= LEVEL_TWO);
      buf_write       = push && !head_from_wdata;
      level_next      = level + W_LEVEL'(push) - W_LEVEL'(pop);
    end
  end

  // Head register, pointers, occupancy and flags. Flags are derived from
  // the next level so they are registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata       <= '0;
      rptr        <= '0;
      wptr        <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      level       <= level_next;
      empty       <= (level_next == '0);
      full        <= (level_next == LEVEL_MAX);
      almost_full <= (level_next >= LEVEL_AF);

      if (flush) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (head_from_wdata) begin
          rdata <= wdata;
        end else if (head_from_buf) begin
          rdata <= mem[rptr];
        end
        if (head_from_buf) begin
          rptr <= ptr_inc(rptr);
        end
        if (buf_write) begin
          wptr <= ptr_inc(wptr);
        end
      end
    end
  end

  // Circular buffer storage behind the head register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (buf_write) begin
      mem[wptr] <= wdata;
    end
  end

`ifdef FORMAL
  // Usage rules on the requesters and internal consistency of the flags.
  a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) !(wen && full));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(ren && empty));
  a_full_empty:    assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));
  a_level_range:   assert property (@(posedge clk) disable iff (!rst_n) level <= LEVEL_MAX);
  a_empty_level:   assert property (@(posedge clk) disable iff (!rst_n) empty == (level == '0));
  a_full_level:    assert property (@(posedge clk) disable iff (!rst_n) full == (level == LEVEL_MAX));
  a_afull_level:   assert property (@(posedge clk) disable iff (!rst_n) almost_full == (level >= LEVEL_AF));
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Testbench for skid_fifo (WIDTH=8, DEPTH=4, AFULL_THRESH=3). A queue model
// records every accepted push and retires entries on accepted pops; each
// scenario task compares the DUT against that queue.
module tb_skid_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;
  localparam int WL    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] wdata;
  logic             wen;
  logic [WIDTH-1:0] rdata;
  logic             ren;
  logic             flush;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic [WL-1:0]    level;

  logic [WIDTH-1:0] model_q [$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WL-1:0]    exp_level;
  logic [WIDTH-1:0] exp_data;

  skid_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AFULL_THRESH(AFT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wdata(wdata),
    .wen(wen),
    .rdata(rdata),
    .ren(ren),
    .flush(flush),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .level(level)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, update the scoreboard for whatever the
  // FIFO should accept on that edge, and return 1 unit after the edge.
  task automatic drive_cycle(input logic w, input logic [WIDTH-1:0] d,
                             input logic r, input logic f);
    bit do_push;
    bit do_pop;
    wen   = w;
    wdata = d;
    ren   = r;
    flush = f;
    do_push = w && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    #1;
    wen   = 1'b0;
    ren   = 1'b0;
    flush = 1'b0;
  endtask

  // Reset values while rst_n is held low, and empty once released.
  task automatic test_reset();
    rst_n = 1'b0;
    wen = 1'b0; ren = 1'b0; flush = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (level !== '0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_afull: got %b expected 0", almost_full); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 00", rdata); end
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL release_empty: got %b expected 1", empty); end
  endtask

  // A write into an empty FIFO shows up on rdata exactly one cycle later.
  task automatic test_first_word();
    wen   = 1'b1;
    wdata = 8'h11;
    #1;
    n_checks++; if (rdata === 8'h11) begin n_fail++; $display("[TB] FAIL early_rdata: got %h before the clock edge", rdata); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL early_empty: got %b expected 1", empty); end
    drive_cycle(1'b1, 8'h11, 1'b0, 1'b0);
    exp_level = WL'(model_q.size());
    n_checks++; if (rdata !== model_q[0]) begin n_fail++; $display("[TB] FAIL first_rdata: got %h expected %h", rdata, model_q[0]); end
    n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL first_level: got %0d expected %0d", level, exp_level); end
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("[TB] FAIL first_empty: got %b expected 0", empty); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL first_drain_empty: got %b expected 1", empty); end
  endtask

  // Fill to capacity watching the flags, then drain in order.
  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      drive_cycle(1'b1, WIDTH'(i), 1'b0, 1'b0);
      exp_level = WL'(model_q.size());
      n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL fill_level[%0d]: got %0d expected %0d", i, level, exp_level); end
      n_checks++; if (almost_full !== (model_q.size() >= AFT)) begin n_fail++; $display("[TB] FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, model_q.size() >= AFT); end
      n_checks++; if (full !== (model_q.size() == DEPTH)) begin n_fail++; $display("[TB] FAIL fill_full[%0d]: got %b expected %b", i, full, model_q.size() == DEPTH); end
      n_checks++; if (rdata !== model_q[0]) begin n_fail++; $display("[TB] FAIL fill_rdata[%0d]: got %h expected %h", i, rdata, model_q[0]); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_data = model_q[0];
      n_checks++; if (rdata !== exp_data) begin n_fail++; $display("[TB] FAIL drain_rdata[%0d]: got %h expected %h", i, rdata, exp_data); end
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      exp_level = WL'(model_q.size());
      n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL drain_level[%0d]: got %0d expected %0d", i, level, exp_level); end
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
  endtask

  // Continuous push+pop at level 1: the head bypasses wdata every cycle.
  task automatic test_back_to_back();
    drive_cycle(1'b1, 8'h1F, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, WIDTH'(8'h20 + i), 1'b1, 1'b0);
      exp_level = WL'(model_q.size());
      n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL b2b_level[%0d]: got %0d expected %0d", i, level, exp_level); end
      n_checks++; if (rdata !== model_q[0]) begin n_fail++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", i, rdata, model_q[0]); end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_empty: got %b expected 1", empty); end
  endtask

  // Steady push+pop at level 3 so both pointers wrap the 3-entry buffer.
  task automatic test_wrap();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, WIDTH'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, WIDTH'(8'h50 + i), 1'b1, 1'b0);
      exp_level = WL'(model_q.size());
      n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL wrap_level[%0d]: got %0d expected %0d", i, level, exp_level); end
      n_checks++; if (rdata !== model_q[0]) begin n_fail++; $display("[TB] FAIL wrap_rdata[%0d]: got %h expected %h", i, rdata, model_q[0]); end
    end
    for (int i = 0; i < 3; i++) begin
      exp_data = model_q[0];
      n_checks++; if (rdata !== exp_data) begin n_fail++; $display("[TB] FAIL wrap_drain[%0d]: got %h expected %h", i, rdata, exp_data); end
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  // Flush wins over a simultaneous pop; the FIFO is usable straight after.
  task automatic test_flush();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, WIDTH'(8'h60 + i), 1'b0, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("[TB] FAIL preflush_full: got %b expected 1", full); end
    drive_cycle(1'b0, '0, 1'b1, 1'b1);
    exp_level = WL'(model_q.size());
    n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL flush_level: got %0d expected %0d", level, exp_level); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_full: got %b expected 0", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_afull: got %b expected 0", almost_full); end
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    exp_level = WL'(model_q.size());
    n_checks++; if (rdata !== model_q[0]) begin n_fail++; $display("[TB] FAIL postflush_rdata: got %h expected %h", rdata, model_q[0]); end
    n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL postflush_level: got %0d expected %0d", level, exp_level); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  // Reset asserted between clock edges must clear state without a clock.
  task automatic test_async_reset();
    drive_cycle(1'b1, 8'h71, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h72, 1'b0, 1'b0);
    exp_level = WL'(model_q.size());
    n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL prereset_level: got %0d expected %0d", level, exp_level); end
    #1;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    n_checks++; if (level !== '0) begin n_fail++; $display("[TB] FAIL async_level: got %0d expected 0", level); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL async_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("[TB] FAIL async_full: got %b expected 0", full); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("[TB] FAIL async_afull: got %b expected 0", almost_full); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("[TB] FAIL async_rdata: got %h expected 00", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 8'h81, 1'b0, 1'b0);
    drive_cycle(1'b1, 8'h82, 1'b0, 1'b0);
    exp_level = WL'(model_q.size());
    n_checks++; if (rdata !== model_q[0]) begin n_fail++; $display("[TB] FAIL resume_rdata0: got %h expected %h", rdata, model_q[0]); end
    n_checks++; if (level !== exp_level) begin n_fail++; $display("[TB] FAIL resume_level: got %0d expected %0d", level, exp_level); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (rdata !== model_q[0]) begin n_fail++; $display("[TB] FAIL resume_rdata1: got %h expected %h", rdata, model_q[0]); end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("[TB] FAIL resume_empty: got %b expected 1", empty); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_first_word();
    test_fill_drain();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against the run never finishing.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
